// File: rtl/branch_predict_unit_pkg.sv
// Shared opcode constants, BHT counter states and helpers for the branch predict unit.
package branch_predict_unit_pkg;

    localparam logic RST_ENABLED = 1'b0;

    localparam logic [5:0] BEQ_OP  = 6'b000100;
    localparam logic [5:0] BNE_OP  = 6'b000101;
    localparam logic [5:0] J_OP    = 6'b000010;
    localparam logic [5:0] JAL_OP  = 6'b000011;
    localparam logic [5:0] JR_OP   = 6'b000000;
    localparam logic [5:0] JR_FUNC = 6'b001000;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_state_e;

    function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == ST) ? ST : cnt + 2'd1;
        end
        return (cnt == SNT) ? SNT : cnt - 2'd1;
    endfunction

    function automatic logic is_jr(input logic [5:0] op, input logic [5:0] func);
        return (op == JR_OP) && (func == JR_FUNC);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch classification and outcome evaluation for the EX stage.
module branch_cond_eval
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [5:0]        op,
    input  logic [5:0]        func,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    output logic              is_branch,
    output logic              is_cond,
    output logic              taken
);

    always_comb begin
        is_branch = 1'b0;
        is_cond   = 1'b0;
        taken     = 1'b0;
        case (op)
            BEQ_OP: begin
                is_branch = 1'b1;
                is_cond   = 1'b1;
                taken     = (data1 == data2);
            end
            BNE_OP: begin
                is_branch = 1'b1;
                is_cond   = 1'b1;
                taken     = (data1 != data2);
            end
            J_OP, JAL_OP: begin
                is_branch = 1'b1;
                taken     = 1'b1;
            end
            JR_OP: begin
                is_branch = (func == JR_FUNC);
                taken     = (func == JR_FUNC);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor: 2-bit saturating BHT lookup in ID, resolve/train with registered flush in EX.
// Optional statistics counters are enabled by defining BPU_STATS_EN.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IDX_W    = 6,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [5:0]        id_op,
    output logic              id_pred_taken,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic [5:0]        ex_op,
    input  logic [5:0]        ex_func,
    input  logic [DATA_W-1:0] ex_data1,
    input  logic [DATA_W-1:0] ex_data2,
    input  logic [DATA_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    output logic              flush,
    output logic [DATA_W-1:0] redirect_pc
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam int unsigned Entries = 1 << IDX_W;

    logic [1:0]        bht_q [Entries];
    logic [1:0]        bht_d [Entries];
    logic              flush_q, flush_d;
    logic [DATA_W-1:0] redirect_q, redirect_d;

    logic [IDX_W-1:0]  id_idx, ex_idx;
    logic              is_branch, is_cond, taken;
    logic              accept, mispredict;
    logic              unused_id_pc;

    assign unused_id_pc = ^{id_pc[DATA_W-1:IDX_W+2], id_pc[1:0]};

    assign id_idx = id_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // Lookup reads the registered table only; a same-cycle write is not bypassed.
    always_comb begin
        id_pred_taken = 1'b0;
        if (id_valid) begin
            case (id_op)
                BEQ_OP, BNE_OP: id_pred_taken = bht_q[id_idx][1];
                J_OP, JAL_OP:   id_pred_taken = 1'b1;
                default:        id_pred_taken = 1'b0;
            endcase
        end
    end

    branch_cond_eval #(
        .DATA_W (DATA_W)
    ) u_cond (
        .op        (ex_op),
        .func      (ex_func),
        .data1     (ex_data1),
        .data2     (ex_data2),
        .is_branch (is_branch),
        .is_cond   (is_cond),
        .taken     (taken)
    );

    // The EX instruction during a flush cycle is on the wrong path.
    assign accept     = ex_valid & ~flush_q;
    assign mispredict = accept & is_branch & (taken != ex_pred_taken);

    always_comb begin
        flush_d    = mispredict;
        redirect_d = redirect_q;
        if (mispredict) begin
            if (!taken) begin
                redirect_d = ex_pc + DATA_W'(4);
            end else if (is_jr(ex_op, ex_func)) begin
                redirect_d = ex_data1;
            end else begin
                redirect_d = ex_target;
            end
        end
    end

    always_comb begin
        bht_d = bht_q;
        if (accept && is_cond) begin
            bht_d[ex_idx] = cnt_update(bht_q[ex_idx], taken);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLED) begin
            flush_q    <= 1'b0;
            redirect_q <= '0;
            for (int i = 0; i < int'(Entries); i++) begin
                bht_q[i] <= CNT_INIT;
            end
        end else begin
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            bht_q      <= bht_d;
        end
    end

    assign flush       = flush_q;
    assign redirect_pc = redirect_q;

`ifdef BPU_STATS_EN
    logic [31:0] stat_br_q, stat_br_d, stat_mis_q, stat_mis_d;

    always_comb begin
        stat_br_d  = stat_br_q;
        stat_mis_d = stat_mis_q;
        if (accept && is_branch && (stat_br_q != 32'hFFFF_FFFF)) begin
            stat_br_d = stat_br_q + 32'd1;
        end
        if (mispredict && (stat_mis_q != 32'hFFFF_FFFF)) begin
            stat_mis_d = stat_mis_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLED) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (stats checks when BPU_STATS_EN is defined).
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [5:0]  id_op;
    logic        id_pred_taken;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [5:0]  ex_op;
    logic [5:0]  ex_func;
    logic [31:0] ex_data1;
    logic [31:0] ex_data2;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        flush;
    logic [31:0] redirect_pc;
`ifdef BPU_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .DATA_W   (32),
        .IDX_W    (6),
        .CNT_INIT (2'b01)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_op         (id_op),
        .id_pred_taken (id_pred_taken),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_op         (ex_op),
        .ex_func       (ex_func),
        .ex_data1      (ex_data1),
        .ex_data2      (ex_data2),
        .ex_target     (ex_target),
        .ex_pred_taken (ex_pred_taken),
        .flush         (flush),
        .redirect_pc   (redirect_pc)
`ifdef BPU_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [5:0] op, input logic [5:0] func, input logic [31:0] pc,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] tgt,
                          input logic pred);
        ex_valid      = 1'b1;
        ex_op         = op;
        ex_func       = func;
        ex_pc         = pc;
        ex_data1      = d1;
        ex_data2      = d2;
        ex_target     = tgt;
        ex_pred_taken = pred;
    endtask

    task automatic lookup(input logic [5:0] op, input logic [31:0] pc, input logic exp,
                          input string tag);
        id_valid = 1'b1;
        id_op    = op;
        id_pc    = pc;
        #1;
        check(tag, {31'd0, id_pred_taken}, {31'd0, exp});
    endtask

    initial begin
        rst = 1'b0;
        id_valid = 0; id_pc = 0; id_op = 0;
        ex_valid = 0; ex_pc = 0; ex_op = 0; ex_func = 0;
        ex_data1 = 0; ex_data2 = 0; ex_target = 0; ex_pred_taken = 0;

        // Reset state
        step();
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_redirect", redirect_pc, 32'h0);
        rst = 1'b1;
        lookup(6'b000100, 32'h40, 1'b0, "rst_lookup");

        // Train 01 -> 10; lookup in the write cycle sees the old value
        set_ex(6'b000100, 6'h0, 32'h40, 32'd5, 32'd5, 32'h80, 1'b0);
        lookup(6'b000100, 32'h40, 1'b0, "no_bypass");
        step();
        check("train_flush", {31'd0, flush}, 32'd1);
        check("train_redirect", redirect_pc, 32'h80);
        ex_valid = 1'b0;
        lookup(6'b000100, 32'h40, 1'b1, "train_lookup");
        step();
        check("train_pulse_end", {31'd0, flush}, 32'd0);

        // Saturation at 11, then one not-taken -> 10, another -> 01
        set_ex(6'b000100, 6'h0, 32'h40, 32'd5, 32'd5, 32'h80, 1'b1);
        repeat (4) step();
        check("sat_no_flush", {31'd0, flush}, 32'd0);
        set_ex(6'b000100, 6'h0, 32'h40, 32'd5, 32'd6, 32'h80, 1'b1);
        step();
        check("nt_flush", {31'd0, flush}, 32'd1);
        check("nt_redirect", redirect_pc, 32'h44);
        ex_valid = 1'b0;
        lookup(6'b000100, 32'h40, 1'b1, "sat_hi");
        step();
        set_ex(6'b000100, 6'h0, 32'h40, 32'd5, 32'd6, 32'h80, 1'b1);
        step();
        check("nt2_flush", {31'd0, flush}, 32'd1);
        ex_valid = 1'b0;
        lookup(6'b000100, 32'h40, 1'b0, "nt2_lookup");
        step();

        // BNE not-taken redirect, then saturation at 00
        set_ex(6'b000101, 6'h0, 32'h100, 32'd7, 32'd7, 32'h500, 1'b1);
        step();
        check("bne_flush", {31'd0, flush}, 32'd1);
        check("bne_redirect", redirect_pc, 32'h104);
        ex_valid = 1'b0;
        step();
        set_ex(6'b000101, 6'h0, 32'h100, 32'd7, 32'd7, 32'h500, 1'b0);
        step();
        check("bne_correct_no_flush", {31'd0, flush}, 32'd0);
        ex_valid = 1'b0;
        lookup(6'b000101, 32'h100, 1'b0, "bne_sat_lo");

        // JR uses data1 and does not touch the BHT
        set_ex(6'b000000, 6'b001000, 32'h208, 32'h2000, 32'd0, 32'h999, 1'b0);
        step();
        check("jr_flush", {31'd0, flush}, 32'd1);
        check("jr_redirect", redirect_pc, 32'h2000);
        ex_valid = 1'b0;
        lookup(6'b000100, 32'h208, 1'b0, "jr_no_bht");
        lookup(6'b000000, 32'h208, 1'b0, "jr_lookup");
        lookup(6'b000010, 32'h208, 1'b1, "j_lookup");
        id_valid = 1'b0;
        #1;
        check("idle_lookup", {31'd0, id_pred_taken}, 32'd0);
        step();

        // JAL mispredict, J correct, non-branch ignored
        set_ex(6'b000011, 6'h0, 32'h400, 32'd0, 32'd0, 32'h1234, 1'b0);
        step();
        check("jal_redirect", redirect_pc, 32'h1234);
        ex_valid = 1'b0;
        step();
        set_ex(6'b000010, 6'h0, 32'h404, 32'd0, 32'd0, 32'h1300, 1'b1);
        step();
        check("j_no_flush", {31'd0, flush}, 32'd0);
        set_ex(6'b100011, 6'h0, 32'h408, 32'd1, 32'd1, 32'h1400, 1'b1);
        step();
        check("nonbranch_no_flush", {31'd0, flush}, 32'd0);

        // Squash: mispredicting BEQ during the flush cycle is ignored
        set_ex(6'b000100, 6'h0, 32'h30C, 32'd1, 32'd1, 32'h600, 1'b0);
        step();
        check("sq_first_flush", {31'd0, flush}, 32'd1);
        check("sq_first_redirect", redirect_pc, 32'h600);
        set_ex(6'b000100, 6'h0, 32'h310, 32'd2, 32'd2, 32'h700, 1'b0);
        step();
        check("sq_no_flush", {31'd0, flush}, 32'd0);
        ex_valid = 1'b0;
        lookup(6'b000100, 32'h310, 1'b0, "sq_bht_unchanged");
        lookup(6'b000100, 32'h30C, 1'b1, "sq_first_trained");

        // PC+4 wraps at the top of the address space
        set_ex(6'b000101, 6'h0, 32'hFFFF_FFFC, 32'd3, 32'd3, 32'h800, 1'b1);
        step();
        check("wrap_flush", {31'd0, flush}, 32'd1);
        check("wrap_redirect", redirect_pc, 32'h0);
        ex_valid = 1'b0;
`ifdef BPU_STATS_EN
        check("stat_branches", stat_branches, 32'd14);
        check("stat_mispredicts", stat_mispredicts, 32'd8);
`endif

        // Asynchronous reset during a flush pulse
        rst = 1'b0;
        #1;
        check("rst_mid_flush", {31'd0, flush}, 32'd0);
        check("rst_mid_redirect", redirect_pc, 32'h0);
        lookup(6'b000100, 32'h30C, 1'b0, "rst_bht_cleared");
`ifdef BPU_STATS_EN
        check("rst_stat_branches", stat_branches, 32'd0);
`endif
        rst = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
